hsi_adjust_pipe: RTL and testbench
==================================

HSI_ADJUST_PIPE -- requirements
Module: hsi_adjust_pipe

Interface
REQ-001 Parameter SI_W, default 8, S/I channel width in bits (8..12).
REQ-002 Parameter H_W, default 9, hue width in bits.
REQ-003 Parameter H_MAX, default 360, hue full-circle value (exclusive).
REQ-004 Parameter H_STEP, default 15, base hue shift per level.
REQ-005 iCLK  in  1  single clock; all state on rising edge.
REQ-006 iRST_N  in  1  asynchronous active-low reset.
REQ-007 iValid  in  1  input pixel valid.
REQ-008 iSOF  in  1  start-of-frame marker, qualified by iValid.
REQ-009 iH/iS/iI  in  H_W/SI_W/SI_W  input pixel; iH < H_MAX guaranteed.
REQ-010 iReady  in  1  downstream ready; low stalls the pipeline.
REQ-011 oReady  out  1  upstream ready; equals iReady combinationally.
REQ-012 iModeH/iModeS/iModeI  in  3 each  {enable, sel[1:0]} adjustment mode per channel.
REQ-013 oValid/oSOF  out  1 each  output valid and aligned frame marker.
REQ-014 oH/oS/oI  out  H_W/SI_W/SI_W  adjusted pixel.

Function
REQ-015 Pipeline advances only when iReady=1; with iReady=0 all pipeline registers, shadow modes and outputs hold.
REQ-016 Latency is exactly 2 advancing cycles from accepted input to output; oSOF travels with its pixel.
REQ-017 Mode inputs are sampled into shadow registers only on an accepted beat with iSOF=1, and that beat already uses the new modes; mid-frame mode changes have no effect until the next iSOF.
REQ-018 Stage 1 computes unclamped results at width+1 bits; stage 2 saturates: S/I to 2^SI_W-1, H to H_MAX (when the clamped result equals H_MAX it is passed as H_MAX).
REQ-019 Hue, enable=0: oH=iH; sel[1]=0 pulls toward 240 with shift D=H_STEP*(1+sel[0]); sel[1]=1 pulls toward 60 with same D.
REQ-020 Pull-to-240: if 60<h<=240 then out=min(h+D,240); else if h<D out=h+H_MAX-D; else if 60<h<240+D out=240; else out=h-D.
REQ-021 Pull-to-60: if 60<h<=240 then out=max(h-D,60); else if h>H_MAX-D out=h+D-H_MAX; else if 60-D<h<240 out=60; else out=h+D.
REQ-022 Let F=2^SI_W, HF=F/2, Q=F/4, E=F/8; x is the channel value; enable=0 passes x through.
REQ-023 S sel 0: x<HF ? x>>1 : x+(x>>1)-HF; sel 1: x<HF ? x-(x>>2) : x+(x>>2)-Q.
REQ-024 S sel 2: E<x<=HF ? x+(x>>2)-E/4 : HF<x<7E ? x-(x>>2)+7E/4 : x; sel 3 same with >>1, -E/2, +7E/2.
REQ-025 I sel 0: x<Q ? x+(x>>1) : x<3Q ? (x>>1)+Q : x+(x>>1)-HF; sel 1: x<Q ? x+(x>>2) : x<3Q ? x-(x>>2)+E : x+(x>>2)-Q.
REQ-026 I sel 2: x<Q ? x-(x>>2) : x<3Q ? x+(x>>2)-E : x-(x>>2)+Q; sel 3: x<Q ? x>>1 : x<3Q ? x+(x>>1)-Q : (x>>1)+HF.
REQ-027 oValid is 1 only for beats carrying an accepted input; bubbles propagate as oValid=0.

Reset
REQ-028 On iRST_N=0, immediately: oValid=0, oSOF=0, oH/oS/oI=0, all pipeline valids=0, shadow modes=0 (pass-through).
REQ-029 Reset mid-frame discards in-flight pixels; after release, pass-through applies until the first accepted iSOF.

Configuration
REQ-030 Macro HSI_ADJUST_STATS_EN: when defined, adds outputs oISum (SI_W+22 bits) and oStatValid (1); the block accumulates output I of each valid output beat, and on each output oSOF beat loads oISum with the previous frame total and pulses oStatValid for 1 cycle, restarting the accumulator at that beat's oI.
REQ-031 Without HSI_ADJUST_STATS_EN, those ports and the accumulator do not exist; all other behaviour is identical.

Verification
REQ-032 All modes 0, SI_W=8, 1000 random pixels, iReady=1 -> outputs equal inputs, delayed 2 cycles.
REQ-033 iSOF beat with iModeH=3'b100, iH=230 -> oH=240; iH=10 -> oH=355; iH=250 -> oH=240; iH=300 -> oH=285.
REQ-034 iModeS=3'b100, iS=200 then iModeI=3'b111, iI=250 -> oS=172, oI=253; iModeS change mid-frame with iS=200 -> unchanged result.
REQ-035 iReady low for 5 cycles with 2 pixels in flight -> outputs frozen, no loss or duplication; release -> pixels emerge in order.
REQ-036 iRST_N asserted mid-frame between edges -> oValid=0 without clock edge; next frame without iSOF passes through.
REQ-037 STATS_EN, frame of 4 pixels with oI=10,20,30,40 followed by oSOF -> oISum=100, oStatValid one cycle.

Source files
------------

// File: rtl/hsi_adjust_pipe.sv
`timescale 1ns/1ps
// HSI pixel adjust: per-channel hue pull / S,I tone curves, modes latched at start of frame.
// Latency: 2 advancing cycles (stage 1 unclamped math, stage 2 saturation). Optional HSI_ADJUST_STATS_EN.
// Backpressure: iReady=0 freezes every register; oReady mirrors iReady combinationally.
module hsi_adjust_pipe #(
    parameter int SI_W   = 8,
    parameter int H_W    = 9,
    parameter int H_MAX  = 360,
    parameter int H_STEP = 15
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    input  logic            iValid,
    input  logic            iSOF,
    input  logic [H_W-1:0]  iH,
    input  logic [SI_W-1:0] iS,
    input  logic [SI_W-1:0] iI,
    input  logic            iReady,
    output logic            oReady,
    input  logic [2:0]      iModeH,
    input  logic [2:0]      iModeS,
    input  logic [2:0]      iModeI,
    output logic            oValid,
    output logic            oSOF,
    output logic [H_W-1:0]  oH,
    output logic [SI_W-1:0] oS,
    output logic [SI_W-1:0] oI
`ifdef HSI_ADJUST_STATS_EN
    ,
    output logic [SI_W+21:0] oISum,
    output logic             oStatValid
`endif
);
    localparam int HX = H_W + 1;
    localparam int SX = SI_W + 1;

    localparam logic [HX-1:0] HMAX_X = HX'(H_MAX);
    localparam logic [HX-1:0] H_LO   = HX'(60);
    localparam logic [HX-1:0] H_HI   = HX'(240);
    localparam logic [HX-1:0] D1     = HX'(H_STEP);
    localparam logic [HX-1:0] D2     = HX'(2 * H_STEP);

    localparam logic [SX-1:0] F_MAX = SX'((1 << SI_W) - 1);
    localparam logic [SX-1:0] HF    = SX'(1 << (SI_W - 1));
    localparam logic [SX-1:0] Q     = SX'(1 << (SI_W - 2));
    localparam logic [SX-1:0] Q3    = SX'(3 << (SI_W - 2));
    localparam logic [SX-1:0] E     = SX'(1 << (SI_W - 3));
    localparam logic [SX-1:0] E7    = SX'(7 << (SI_W - 3));
    localparam logic [SX-1:0] E_4   = SX'(1 << (SI_W - 5));
    localparam logic [SX-1:0] E7_4  = SX'(7 << (SI_W - 5));
    localparam logic [SX-1:0] E_2   = SX'(1 << (SI_W - 4));
    localparam logic [SX-1:0] E7_2  = SX'(7 << (SI_W - 4));

    function automatic logic [HX-1:0] hue_fn(input logic [H_W-1:0] h, input logic [2:0] m);
        logic [HX-1:0] hx, d, r;
        hx = {1'b0, h};
        d  = m[0] ? D2 : D1;
        r  = hx;
        if (m[2] && !m[1]) begin
            if (hx > H_LO && hx <= H_HI)      r = (hx + d > H_HI) ? H_HI : hx + d;
            else if (hx < d)                  r = hx + HMAX_X - d;
            else if (hx > H_LO && hx < H_HI + d) r = H_HI;
            else                              r = hx - d;
        end else if (m[2]) begin
            if (hx > H_LO && hx <= H_HI)      r = (hx < H_LO + d) ? H_LO : hx - d;
            else if (hx > HMAX_X - d)         r = hx + d - HMAX_X;
            else if (hx > H_LO - d && hx < H_HI) r = H_LO;
            else                              r = hx + d;
        end
        return r;
    endfunction

    function automatic logic [SX-1:0] sat_fn(input logic [SI_W-1:0] x, input logic [2:0] m);
        logic [SX-1:0] v, r;
        v = {1'b0, x};
        r = v;
        if (m[2]) begin
            case (m[1:0])
                2'd0:    r = (v < HF) ? v >> 1 : v + (v >> 1) - HF;
                2'd1:    r = (v < HF) ? v - (v >> 2) : v + (v >> 2) - Q;
                2'd2:    r = (v > E && v <= HF) ? v + (v >> 2) - E_4 :
                             (v > HF && v < E7) ? v - (v >> 2) + E7_4 : v;
                default: r = (v > E && v <= HF) ? v + (v >> 1) - E_2 :
                             (v > HF && v < E7) ? v - (v >> 1) + E7_2 : v;
            endcase
        end
        return r;
    endfunction

    function automatic logic [SX-1:0] int_fn(input logic [SI_W-1:0] x, input logic [2:0] m);
        logic [SX-1:0] v, r;
        v = {1'b0, x};
        r = v;
        if (m[2]) begin
            case (m[1:0])
                2'd0:    r = (v < Q) ? v + (v >> 1) : (v < Q3) ? (v >> 1) + Q : v + (v >> 1) - HF;
                2'd1:    r = (v < Q) ? v + (v >> 2) : (v < Q3) ? v - (v >> 2) + E : v + (v >> 2) - Q;
                2'd2:    r = (v < Q) ? v - (v >> 2) : (v < Q3) ? v + (v >> 2) - E : v - (v >> 2) + Q;
                default: r = (v < Q) ? v >> 1 : (v < Q3) ? v + (v >> 1) - Q : (v >> 1) + HF;
            endcase
        end
        return r;
    endfunction

    logic [2:0]    shd_h, shd_s, shd_i;
    logic [2:0]    mode_h, mode_s, mode_i;
    logic          sof_beat;
    logic          s1_vld, s1_sof;
    logic [HX-1:0] s1_h;
    logic [SX-1:0] s1_s, s1_i;
    logic [H_W-1:0]  h_sat;
    logic [SI_W-1:0] s_sat, i_sat;

    assign oReady   = iReady;
    assign sof_beat = iValid & iSOF;

    // The frame-start beat itself already uses the freshly presented modes.
    assign mode_h = sof_beat ? iModeH : shd_h;
    assign mode_s = sof_beat ? iModeS : shd_s;
    assign mode_i = sof_beat ? iModeI : shd_i;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            shd_h  <= '0;
            shd_s  <= '0;
            shd_i  <= '0;
            s1_vld <= 1'b0;
            s1_sof <= 1'b0;
            s1_h   <= '0;
            s1_s   <= '0;
            s1_i   <= '0;
        end else if (iReady) begin
            s1_vld <= iValid;
            s1_sof <= sof_beat;
            s1_h   <= hue_fn(iH, mode_h);
            s1_s   <= sat_fn(iS, mode_s);
            s1_i   <= int_fn(iI, mode_i);
            if (sof_beat) begin
                shd_h <= iModeH;
                shd_s <= iModeS;
                shd_i <= iModeI;
            end
        end
    end

    assign h_sat = (s1_h > HMAX_X) ? H_W'(H_MAX) : s1_h[H_W-1:0];
    assign s_sat = (s1_s > F_MAX) ? {SI_W{1'b1}} : s1_s[SI_W-1:0];
    assign i_sat = (s1_i > F_MAX) ? {SI_W{1'b1}} : s1_i[SI_W-1:0];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oValid <= 1'b0;
            oSOF   <= 1'b0;
            oH     <= '0;
            oS     <= '0;
            oI     <= '0;
        end else if (iReady) begin
            oValid <= s1_vld;
            oSOF   <= s1_sof;
            oH     <= h_sat;
            oS     <= s_sat;
            oI     <= i_sat;
        end
    end

`ifdef HSI_ADJUST_STATS_EN
    logic [SI_W+21:0] i_acc;

    // Accumulate on the cycle a beat is loaded into the output stage so a stall never double-counts.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            i_acc      <= '0;
            oISum      <= '0;
            oStatValid <= 1'b0;
        end else begin
            oStatValid <= 1'b0;
            if (iReady && s1_vld) begin
                if (s1_sof) begin
                    oISum      <= i_acc;
                    oStatValid <= 1'b1;
                    i_acc      <= {22'd0, i_sat};
                end else begin
                    i_acc <= i_acc + {22'd0, i_sat};
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_hsi_adjust_pipe.sv
`timescale 1ns/1ps
// Scoreboard bench for hsi_adjust_pipe: directed vectors push expected beats, a negedge monitor pops them.
module tb_hsi_adjust_pipe;
    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       iValid = 1'b0;
    logic       iSOF = 1'b0;
    logic [8:0] iH = '0;
    logic [7:0] iS = '0;
    logic [7:0] iI = '0;
    logic       iReady = 1'b1;
    logic       oReady;
    logic [2:0] iModeH = '0;
    logic [2:0] iModeS = '0;
    logic [2:0] iModeI = '0;
    logic       oValid, oSOF;
    logic [8:0] oH;
    logic [7:0] oS, oI;
`ifdef HSI_ADJUST_STATS_EN
    logic [29:0] oISum;
    logic        oStatValid;
`endif

    hsi_adjust_pipe dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iValid(iValid), .iSOF(iSOF),
        .iH(iH), .iS(iS), .iI(iI), .iReady(iReady), .oReady(oReady),
        .iModeH(iModeH), .iModeS(iModeS), .iModeI(iModeI),
        .oValid(oValid), .oSOF(oSOF), .oH(oH), .oS(oS), .oI(oI)
`ifdef HSI_ADJUST_STATS_EN
        , .oISum(oISum), .oStatValid(oStatValid)
`endif
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic       sof;
        logic [8:0] h;
        logic [7:0] s;
        logic [7:0] i;
    } beat_t;

    typedef struct {
        logic [2:0] mh, ms, mi;
        logic [8:0] h;
        logic [7:0] s, i;
        logic [8:0] eh;
        logic [7:0] es, ei;
    } vec_t;

    // modes H/S/I, input h/s/i, expected h/s/i (SI_W=8, H_MAX=360, H_STEP=15)
    vec_t vecs [19] = '{
        '{3'b100, 3'b100, 3'b100, 9'd230, 8'd200, 8'd40,  9'd240, 8'd172, 8'd60},
        '{3'b100, 3'b100, 3'b100, 9'd10,  8'd100, 8'd100, 9'd355, 8'd50,  8'd114},
        '{3'b100, 3'b100, 3'b100, 9'd250, 8'd128, 8'd250, 9'd240, 8'd64,  8'd247},
        '{3'b100, 3'b100, 3'b100, 9'd300, 8'd255, 8'd64,  9'd285, 8'd254, 8'd96},
        '{3'b101, 3'b101, 3'b101, 9'd100, 8'd100, 8'd40,  9'd130, 8'd75,  8'd50},
        '{3'b101, 3'b101, 3'b101, 9'd20,  8'd200, 8'd100, 9'd350, 8'd186, 8'd107},
        '{3'b101, 3'b101, 3'b101, 9'd260, 8'd0,   8'd200, 9'd240, 8'd0,   8'd186},
        '{3'b101, 3'b000, 3'b000, 9'd30,  8'd77,  8'd77,  9'd0,   8'd77,  8'd77},
        '{3'b101, 3'b000, 3'b000, 9'd60,  8'd1,   8'd2,   9'd30,  8'd1,   8'd2},
        '{3'b110, 3'b110, 3'b110, 9'd100, 8'd100, 8'd40,  9'd85,  8'd117, 8'd30},
        '{3'b110, 3'b110, 3'b110, 9'd70,  8'd200, 8'd100, 9'd60,  8'd206, 8'd93},
        '{3'b110, 3'b110, 3'b110, 9'd350, 8'd20,  8'd200, 9'd5,   8'd20,  8'd214},
        '{3'b110, 3'b110, 3'b110, 9'd50,  8'd32,  8'd192, 9'd60,  8'd32,  8'd208},
        '{3'b110, 3'b110, 3'b110, 9'd20,  8'd224, 8'd0,   9'd35,  8'd224, 8'd0},
        '{3'b110, 3'b111, 3'b111, 9'd300, 8'd100, 8'd250, 9'd315, 8'd134, 8'd253},
        '{3'b110, 3'b111, 3'b111, 9'd240, 8'd200, 8'd40,  9'd225, 8'd212, 8'd20},
        '{3'b111, 3'b111, 3'b111, 9'd340, 8'd250, 8'd100, 9'd10,  8'd250, 8'd86},
        '{3'b111, 3'b111, 3'b111, 9'd0,   8'd0,   8'd191, 9'd30,  8'd0,   8'd222},
        '{3'b011, 3'b011, 3'b011, 9'd123, 8'd45,  8'd67,  9'd123, 8'd45,  8'd67}
    };

    beat_t sb[$];
    int    total = 0;
    int    bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at 1 time unit after a rising edge; returns at the same phase after the beat is accepted.
    task automatic send(input logic sof, input logic [2:0] mh, input logic [2:0] ms, input logic [2:0] mi,
                        input logic [8:0] h, input logic [7:0] s, input logic [7:0] i,
                        input logic [8:0] eh, input logic [7:0] es, input logic [7:0] ei);
        iValid = 1'b1;
        iSOF   = sof;
        iModeH = mh;
        iModeS = ms;
        iModeI = mi;
        iH     = h;
        iS     = s;
        iI     = i;
        iReady = 1'b1;
        sb.push_back({sof, eh, es, ei});
        @(posedge iCLK);
        #1;
        iValid = 1'b0;
        iSOF   = 1'b0;
    endtask

    always @(negedge iCLK) begin : monitor
        beat_t got, want;
        if (iRST_N && oValid && iReady) begin
            got = {oSOF, oH, oS, oI};
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat: got sof=%0d h=%0d s=%0d i=%0d, expected no beat",
                         oSOF, oH, oS, oI);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL beat: got sof=%0d h=%0d s=%0d i=%0d expected sof=%0d h=%0d s=%0d i=%0d",
                             got.sof, got.h, got.s, got.i, want.sof, want.h, want.s, want.i);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "simulation timeout");
    end

    initial begin : stim
        logic [8:0] rh;
        logic [7:0] rs, ri;
        logic       rsof;

        #3;
        check("rst_ovalid", {31'd0, oValid}, 0);
        check("rst_osof", {31'd0, oSOF}, 0);
        check("rst_oh", {23'd0, oH}, 0);
        check("rst_os_oi", {16'd0, oS, oI}, 0);
        @(posedge iCLK);
        #3 iRST_N = 1'b1;
        @(posedge iCLK);
        #1;

        // pass-through with all modes off
        for (int n = 0; n < 1000; n++) begin
            rh   = 9'($urandom_range(359, 0));
            rs   = 8'($urandom_range(255, 0));
            ri   = 8'($urandom_range(255, 0));
            rsof = 1'($urandom_range(1, 0));
            send(rsof, 3'b000, 3'b000, 3'b000, rh, rs, ri, rh, rs, ri);
        end

`ifdef HSI_ADJUST_STATS_EN
        send(1'b1, 3'b000, 3'b000, 3'b000, 9'd7, 8'd9, 8'd10, 9'd7, 8'd9, 8'd10);
        send(1'b0, 3'b000, 3'b000, 3'b000, 9'd7, 8'd9, 8'd20, 9'd7, 8'd9, 8'd20);
        send(1'b0, 3'b000, 3'b000, 3'b000, 9'd7, 8'd9, 8'd30, 9'd7, 8'd9, 8'd30);
        send(1'b0, 3'b000, 3'b000, 3'b000, 9'd7, 8'd9, 8'd40, 9'd7, 8'd9, 8'd40);
        send(1'b1, 3'b000, 3'b000, 3'b000, 9'd7, 8'd9, 8'd0, 9'd7, 8'd9, 8'd0);
        @(posedge iCLK);
        #1;
        check("stat_valid_pulse", {31'd0, oStatValid}, 1);
        check("stat_sum", {2'd0, oISum}, 100);
        @(posedge iCLK);
        #1;
        check("stat_valid_drop", {31'd0, oStatValid}, 0);
`endif

        foreach (vecs[k])
            send(1'b1, vecs[k].mh, vecs[k].ms, vecs[k].mi, vecs[k].h, vecs[k].s, vecs[k].i,
                 vecs[k].eh, vecs[k].es, vecs[k].ei);

        // modes change mid-frame must be ignored until the next frame start
        send(1'b1, 3'b000, 3'b100, 3'b111, 9'd5, 8'd200, 8'd250, 9'd5, 8'd172, 8'd253);
        send(1'b0, 3'b100, 3'b000, 3'b000, 9'd5, 8'd200, 8'd250, 9'd5, 8'd172, 8'd253);

        // two beats in flight, then a 5-cycle stall with a third beat waiting
        send(1'b0, 3'b000, 3'b000, 3'b000, 9'd11, 8'd100, 8'd40, 9'd11, 8'd50, 8'd20);
        send(1'b0, 3'b000, 3'b000, 3'b000, 9'd12, 8'd128, 8'd100, 9'd12, 8'd64, 8'd86);
        iValid = 1'b1;
        iH     = 9'd13;
        iS     = 8'd200;
        iI     = 8'd250;
        iReady = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge iCLK);
            #1;
            check("stall_oready", {31'd0, oReady}, 0);
            check("stall_ovalid", {31'd0, oValid}, 1);
            check("stall_oh", {23'd0, oH}, 11);
            check("stall_os_oi", {16'd0, oS, oI}, {16'd0, 8'd50, 8'd20});
        end
        send(1'b0, 3'b000, 3'b000, 3'b000, 9'd13, 8'd200, 8'd250, 9'd13, 8'd172, 8'd253);
        check("oready_high", {31'd0, oReady}, 1);

        // asynchronous reset with two beats in flight
        send(1'b1, 3'b100, 3'b100, 3'b100, 9'd230, 8'd200, 8'd40, 9'd240, 8'd172, 8'd60);
        send(1'b0, 3'b100, 3'b100, 3'b100, 9'd10, 8'd100, 8'd100, 9'd355, 8'd50, 8'd114);
        #2 iRST_N = 1'b0;
        #1;
        check("arst_ovalid", {31'd0, oValid}, 0);
        check("arst_oh", {23'd0, oH}, 0);
        check("arst_osof", {31'd0, oSOF}, 0);
        sb.delete();
        @(posedge iCLK);
        #3 iRST_N = 1'b1;
        @(posedge iCLK);
        #1;
        send(1'b0, 3'b100, 3'b100, 3'b100, 9'd230, 8'd200, 8'd40, 9'd230, 8'd200, 8'd40);
        send(1'b0, 3'b101, 3'b111, 3'b111, 9'd10, 8'd100, 8'd250, 9'd10, 8'd100, 8'd250);

        for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge iCLK);
        check("drain_left", sb.size(), 0);
        #20;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
